// File: rtl/multi_fade_pwm.sv
// Multi-channel LED fader: per-channel brightness ramps (triangle, sawtooth,
//   one-shot, hold) driving PWM outputs from one shared free-running counter.
// Latency: o_level is combinational from the level registers; o_led/o_wrap are
//   registered one cycle after the state they reflect. No backpressure; i_enable
//   low freezes every register and holds o_wrap low.
//
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_enable        run (1) / freeze (0)
//   i_speed         per-channel step period in enabled cycles (0 = never step)
//   i_mode          per-channel mode: 0 triangle, 1 sawtooth, 2 one-shot, 3 hold
//   o_led           registered PWM output per channel
//   o_level         current brightness per channel
//   o_wrap          one-cycle pulse when a channel completes its period
module multi_fade_pwm #(
  parameter int CHANNELS   = 4,
  parameter int PWM_BITS   = 10,
  parameter int SPEED_BITS = 11
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enable,
  input  logic [CHANNELS*SPEED_BITS-1:0] i_speed,
  input  logic [2*CHANNELS-1:0]          i_mode,
  output logic [CHANNELS-1:0]            o_led,
  output logic [CHANNELS*PWM_BITS-1:0]   o_level,
  output logic [CHANNELS-1:0]            o_wrap
);

  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO = '0;
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

  localparam logic [1:0] MODE_TRI  = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_ONE  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Shared PWM ramp; every channel compares against the same count so all
  // outputs share one PWM period.
  logic [PWM_BITS-1:0] r_pwm;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm <= '0;
    end else if (i_enable) begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Staggered start so channels do not fade in lockstep.
    localparam logic [PWM_BITS-1:0] RST_LEVEL =
      PWM_BITS'(c * ((2 ** PWM_BITS) / CHANNELS));

    logic [SPEED_BITS-1:0] speed;
    logic [1:0]            mode;
    logic [SPEED_BITS-1:0] div_q, div_d;
    logic                  step;
    logic [PWM_BITS-1:0]   level_q, level_d;
    dir_t                  dir_q, dir_d;
    logic                  wrap_d;
    logic                  led_q, wrap_q;

    assign speed = i_speed[c*SPEED_BITS +: SPEED_BITS];
    assign mode  = i_mode[2*c +: 2];

    // Step divider. The >= compare means a speed lowered below the current
    // count fires on the very next cycle instead of running round the wrap.
    always_comb begin
      div_d = div_q;
      step  = 1'b0;
      if (speed == '0) begin
        div_d = '0;
      end else if (div_q >= speed - 1'b1) begin
        div_d = '0;
        step  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // Level / direction next-state. Every branch guards its end point so a
    // mode change can never push the level outside 0..MAX.
    always_comb begin
      level_d = level_q;
      dir_d   = dir_q;
      wrap_d  = 1'b0;
      if (step) begin
        case (mode)
          MODE_TRI: begin
            if (dir_q == DIR_UP) begin
              if (level_q == MAX) begin
                // Arrived at MAX from another mode with dir still up: turn
                // around instead of overflowing.
                level_d = MAX - 1'b1;
                dir_d   = DIR_DOWN;
              end else begin
                level_d = level_q + 1'b1;
                if (level_q == MAX - 1'b1) begin
                  dir_d = DIR_DOWN;
                end
              end
            end else begin
              if (level_q == LVL_ZERO) begin
                // Down at 0 only after a mode change: bounce without a
                // wrap, since no full period was completed.
                level_d = LVL_ONE;
                dir_d   = DIR_UP;
              end else begin
                level_d = level_q - 1'b1;
                if (level_q == LVL_ONE) begin
                  dir_d  = DIR_UP;
                  wrap_d = 1'b1;
                end
              end
            end
          end
          MODE_SAW: begin
            dir_d = DIR_UP;
            if (level_q == MAX) begin
              level_d = '0;
              wrap_d  = 1'b1;
            end else begin
              level_d = level_q + 1'b1;
            end
          end
          MODE_ONE: begin
            dir_d = DIR_UP;
            if (level_q != MAX) begin
              level_d = level_q + 1'b1;
              if (level_q == MAX - 1'b1) begin
                wrap_d = 1'b1;
              end
            end
          end
          MODE_HOLD: begin
            level_d = level_q;
          end
          default: begin
            level_d = level_q;
          end
        endcase
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        div_q   <= '0;
        level_q <= RST_LEVEL;
        dir_q   <= DIR_UP;
        led_q   <= 1'b0;
        wrap_q  <= 1'b0;
      end else if (i_enable) begin
        div_q   <= div_d;
        level_q <= level_d;
        dir_q   <= dir_d;
        led_q   <= (level_q > r_pwm);
        wrap_q  <= wrap_d;
      end else begin
        wrap_q  <= 1'b0;
      end
    end

    assign o_led[c]                         = led_q;
    assign o_wrap[c]                        = wrap_q;
    assign o_level[c*PWM_BITS +: PWM_BITS]  = level_q;
  end

endmodule

// File: tb/tb_multi_fade_pwm.sv
// Directed testbench for multi_fade_pwm at CHANNELS=2, PWM_BITS=4, SPEED_BITS=4.
// Expected values are hand-derived from the ramp rules; outputs are sampled on
// the falling edge, inputs change on the falling edge.
module tb_multi_fade_pwm;

  localparam int CHANNELS   = 2;
  localparam int PWM_BITS   = 4;
  localparam int SPEED_BITS = 4;

  localparam logic [1:0] M_TRI  = 2'd0;
  localparam logic [1:0] M_SAW  = 2'd1;
  localparam logic [1:0] M_ONE  = 2'd2;
  localparam logic [1:0] M_HOLD = 2'd3;

  logic                           i_clk;
  logic                           i_rst;
  logic                           i_enable;
  logic [CHANNELS*SPEED_BITS-1:0] i_speed;
  logic [2*CHANNELS-1:0]          i_mode;
  logic [CHANNELS-1:0]            o_led;
  logic [CHANNELS*PWM_BITS-1:0]   o_level;
  logic [CHANNELS-1:0]            o_wrap;

  int n_vec;
  int n_err;

  multi_fade_pwm #(
    .CHANNELS  (CHANNELS),
    .PWM_BITS  (PWM_BITS),
    .SPEED_BITS(SPEED_BITS)
  ) u_dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_enable(i_enable),
    .i_speed (i_speed),
    .i_mode  (i_mode),
    .o_led   (o_led),
    .o_level (o_level),
    .o_wrap  (o_wrap)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lvl0();
    return {28'd0, o_level[3:0]};
  endfunction

  function automatic logic [31:0] lvl1();
    return {28'd0, o_level[7:4]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Configure, pulse reset for one cycle, release on a falling edge: the next
  // rising edge is cycle 1 of the test.
  task automatic apply_reset(input logic [3:0] spd1, input logic [3:0] spd0,
                             input logic [1:0] md1, input logic [1:0] md0);
    @(negedge i_clk);
    i_enable = 1'b1;
    i_speed  = {spd1, spd0};
    i_mode   = {md1, md0};
    i_rst    = 1'b1;
    @(negedge i_clk);
    i_rst    = 1'b0;
  endtask

  initial begin
    int wraps;
    int highs0;
    int highs1;
    int exp_l;

    n_vec    = 0;
    n_err    = 0;
    i_rst    = 1'b1;
    i_enable = 1'b1;
    i_speed  = '0;
    i_mode   = {M_HOLD, M_HOLD};

    // Reset state: staggered levels 0 and 16/2*1 = 8, outputs low.
    #1;
    chk("rst lvl0", lvl0(), 0);
    chk("rst lvl1", lvl1(), 8);
    chk("rst led", {30'd0, o_led}, 0);
    chk("rst wrap", {30'd0, o_wrap}, 0);

    // Triangle, speed 2, ch0 from 0: steps on even cycles, 15 at 30, 0 at 60.
    apply_reset(4'd0, 4'd2, M_HOLD, M_TRI);
    wraps = 0;
    for (int n = 1; n <= 60; n++) begin
      tick(1);
      exp_l = (n <= 30) ? n / 2 : 15 - (n - 30) / 2;
      chk($sformatf("tri lvl n=%0d", n), lvl0(), exp_l);
      chk($sformatf("tri wrap n=%0d", n), {31'd0, o_wrap[0]}, (n == 60) ? 1 : 0);
      if (o_wrap[0]) wraps++;
    end
    chk("tri wrap count", wraps, 1);
    chk("tri ch1 held", lvl1(), 8);

    // Sawtooth, speed 1, ch1 from 8: 15 at cycle 7, 0 with wrap at cycle 8.
    apply_reset(4'd1, 4'd0, M_SAW, M_HOLD);
    for (int n = 1; n <= 9; n++) begin
      tick(1);
      exp_l = (n <= 7) ? 8 + n : n - 8;
      chk($sformatf("saw lvl n=%0d", n), lvl1(), exp_l);
      chk($sformatf("saw wrap n=%0d", n), {31'd0, o_wrap[1]}, (n == 8) ? 1 : 0);
    end

    // Duty: ramp ch0 to 4, switch to hold, count lit cycles per 16.
    apply_reset(4'd0, 4'd1, M_HOLD, M_SAW);
    tick(4);
    chk("duty ramp lvl", lvl0(), 4);
    i_mode = {M_HOLD, M_HOLD};
    tick(2);
    chk("duty hold lvl", lvl0(), 4);
    for (int w = 0; w < 2; w++) begin
      highs0 = 0;
      highs1 = 0;
      for (int n = 0; n < 16; n++) begin
        tick(1);
        if (o_led[0]) highs0++;
        if (o_led[1]) highs1++;
      end
      chk($sformatf("duty ch0 win%0d", w), highs0, 4);
      chk($sformatf("duty ch1 win%0d", w), highs1, 8);
    end

    // Speed 0 never steps.
    apply_reset(4'd0, 4'd0, M_TRI, M_TRI);
    tick(100);
    chk("spd0 lvl0", lvl0(), 0);
    chk("spd0 lvl1", lvl1(), 8);

    // Freeze: ch0 sawtooth speed 2, ch1 triangle speed 1. After 5 cycles
    // ch0=2 (divider mid-count), ch1=13, counter=5, led={12>4,2>4}=2'b10.
    apply_reset(4'd1, 4'd2, M_TRI, M_SAW);
    tick(5);
    chk("pre-frz lvl0", lvl0(), 2);
    chk("pre-frz lvl1", lvl1(), 13);
    chk("pre-frz led", {30'd0, o_led}, 2);
    i_enable = 1'b0;
    wraps = 0;
    for (int n = 0; n < 20; n++) begin
      tick(1);
      if (o_wrap != 2'b00) wraps++;
    end
    chk("frz lvl0", lvl0(), 2);
    chk("frz lvl1", lvl1(), 13);
    chk("frz led", {30'd0, o_led}, 2);
    chk("frz wrap cycles", wraps, 0);
    i_enable = 1'b1;
    tick(1);
    chk("resume1 lvl0", lvl0(), 3);
    chk("resume1 lvl1", lvl1(), 14);
    chk("resume1 led", {30'd0, o_led}, 2);
    tick(2);
    chk("resume3 lvl0", lvl0(), 4);
    chk("resume3 lvl1", lvl1(), 14);

    // Lowering speed mid-count fires on the next cycle.
    apply_reset(4'd0, 4'd8, M_HOLD, M_SAW);
    tick(5);
    chk("slow lvl", lvl0(), 0);
    i_speed = {4'd0, 4'd2};
    tick(1);
    chk("lowered lvl a", lvl0(), 1);
    tick(2);
    chk("lowered lvl b", lvl0(), 2);

    // One-shot, speed 1, ch0 from 0: single wrap at 15, then held.
    apply_reset(4'd0, 4'd1, M_HOLD, M_ONE);
    wraps = 0;
    for (int n = 1; n <= 65; n++) begin
      tick(1);
      exp_l = (n < 15) ? n : 15;
      chk($sformatf("one lvl n=%0d", n), lvl0(), exp_l);
      chk($sformatf("one wrap n=%0d", n), {31'd0, o_wrap[0]}, (n == 15) ? 1 : 0);
      if (o_wrap[0]) wraps++;
    end
    chk("one wrap count", wraps, 1);

    // Asynchronous reset mid-cycle while ch0 is lit.
    chk("pre-rst led0", {31'd0, o_led[0]}, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("async rst lvl0", lvl0(), 0);
    chk("async rst lvl1", lvl1(), 8);
    chk("async rst led", {30'd0, o_led}, 0);
    chk("async rst wrap", {30'd0, o_wrap}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
